// File: rtl/axis_frame_rr_arb_if.sv
// Bundle of the S_COUNT packed source streams and the shared sink port of axis_frame_rr_arb.
// The slave modport is the arbiter's view; master is the surrounding sources and sink.
interface axis_frame_rr_arb_if #(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = $clog2(S_COUNT)
) ();

  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [S_COUNT-1:0]            s_axis_tvalid;
  logic [S_COUNT-1:0]            s_axis_tready;
  logic [S_COUNT-1:0]            s_axis_tlast;
  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser;

  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [ID_WIDTH-1:0]           m_axis_tid;
  logic [USER_WIDTH-1:0]         m_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tuser,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tuser,
    output m_axis_tready
  );

endinterface

// File: rtl/axis_frame_rr_arb.sv
// Frame-granular round-robin arbiter: shares one AXI4-Stream sink between S_COUNT sources,
// holding the grant from first beat to tlast, through a single registered output stage.
module axis_frame_rr_arb #(
  parameter int unsigned S_COUNT     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit          USER_ENABLE = 1'b1,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned ID_WIDTH    = $clog2(S_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_frame_rr_arb_if.slave   bus,
  output logic                 status_busy,
  output logic [ID_WIDTH-1:0]  status_grant
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]   pick_c;
  int unsigned           base_c;
  logic                  any_c;
  logic [S_COUNT-1:0]    ready_c;
  logic                  out_ready_c, take_c;

  logic [DATA_WIDTH-1:0] sel_data_c;
  logic [KEEP_WIDTH-1:0] sel_keep_c, beat_keep_c;
  logic [USER_WIDTH-1:0] sel_user_c, beat_user_c;
  logic                  sel_valid_c, sel_last_c;

  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [ID_WIDTH-1:0]   tid_q;
  logic                  tvalid_q, tlast_q;

  // Round-robin pick: nearest requester after last_grant; smaller distance overrides larger.
  always_comb begin
    pick_c = grant_q;
    base_c = 32'(last_grant_q);
    any_c  = |bus.s_axis_tvalid;
    for (int unsigned off = S_COUNT; off >= 1; off--) begin
      for (int unsigned i = 0; i < S_COUNT; i++) begin
        if (bus.s_axis_tvalid[i] && (((base_c + off) % S_COUNT) == i)) begin
          pick_c = ID_WIDTH'(i);
        end
      end
    end
  end

  // Select the granted stream's beat.
  always_comb begin
    sel_data_c  = '0;
    sel_keep_c  = '0;
    sel_user_c  = '0;
    sel_valid_c = 1'b0;
    sel_last_c  = 1'b0;
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_data_c  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep_c  = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user_c  = bus.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_valid_c = bus.s_axis_tvalid[i];
        sel_last_c  = bus.s_axis_tlast[i];
      end
    end
    beat_keep_c = KEEP_ENABLE ? sel_keep_c : {KEEP_WIDTH{1'b1}};
    beat_user_c = USER_ENABLE ? sel_user_c : {USER_WIDTH{1'b0}};
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ready_c      = '0;
    take_c       = 1'b0;
    out_ready_c  = !tvalid_q || bus.m_axis_tready;
    case (state_q)
      IDLE: begin
        if (any_c) begin
          grant_d = pick_c;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        for (int unsigned i = 0; i < S_COUNT; i++) begin
          ready_c[i] = out_ready_c && (grant_q == ID_WIDTH'(i));
        end
        take_c = sel_valid_c && out_ready_c;
        if (take_c && sel_last_c) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(S_COUNT - 1);
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      if (take_c) begin
        tvalid_q <= 1'b1;
      end else if (bus.m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  // Payload registers need no reset; tvalid_q qualifies them.
  always_ff @(posedge clk) begin
    if (take_c) begin
      data_q  <= sel_data_c;
      keep_q  <= beat_keep_c;
      user_q  <= beat_user_c;
      tlast_q <= sel_last_c;
      tid_q   <= grant_q;
    end
  end

  assign bus.s_axis_tready = ready_c;
  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tkeep  = keep_q;
  assign bus.m_axis_tuser  = user_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tid    = tid_q;
  assign status_busy       = (state_q == ACTIVE);
  assign status_grant      = grant_q;

endmodule

// File: tb/tb_axis_frame_rr_arb.sv
// Scoreboard bench for axis_frame_rr_arb: per-source expected-beat queues filled at frame
// creation, drained by a monitor on every accepted output beat; directed cases then random traffic.
module tb_axis_frame_rr_arb;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int UW = 1;
  localparam int IW = 2;

  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  typedef struct packed {int c; int tid; logic [7:0] d; logic l;} log_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_frame_rr_arb_if #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                         .ID_WIDTH(IW)) bus ();
  logic          status_busy;
  logic [IW-1:0] status_grant;

  axis_frame_rr_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW),
                      .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .status_busy(status_busy), .status_grant(status_grant)
  );

  logic [DW-1:0] sd [S];
  logic          sv [S];
  logic          sl [S];
  logic          su [S];
  logic          sk [S];
  logic          mrdy = 1'b0;

  always_comb begin
    for (int i = 0; i < S; i++) begin
      bus.s_axis_tdata[i*DW +: DW] = sd[i];
      bus.s_axis_tvalid[i]         = sv[i];
      bus.s_axis_tlast[i]          = sl[i];
      bus.s_axis_tuser[i]          = su[i];
      bus.s_axis_tkeep[i]          = sk[i];
    end
  end
  assign bus.m_axis_tready = mrdy;

  beat_t exp_q [S][$];
  log_t  log_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    t0 = 0;
  int    cur_src = -1;
  bit    abort = 1'b0;
  bit    done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: stall stability, ready exclusivity and scoreboard on every accepted output beat.
  logic          hold_v = 1'b0;
  logic [7:0]    hd;
  logic          hl, hu;
  logic [IW-1:0] ht;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      check("ready_onehot", 32'($countones(bus.s_axis_tready) <= 1), 32'd1);
      if (hold_v)
        check("stall_stable",
              {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tid, bus.m_axis_tuser},
              {1'b1, hd, hl, ht, hu});
      if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
        check("stall_no_ready", 32'(bus.s_axis_tready), 32'd0);
        hold_v = 1'b1;
        hd = bus.m_axis_tdata; hl = bus.m_axis_tlast; ht = bus.m_axis_tid; hu = bus.m_axis_tuser;
      end else begin
        hold_v = 1'b0;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        int t;
        beat_t e;
        t = int'(bus.m_axis_tid);
        log_q.push_back('{c: cyc - t0, tid: t, d: bus.m_axis_tdata, l: bus.m_axis_tlast});
        if (cur_src >= 0) check("frame_contiguous", 32'(t), 32'(cur_src));
        if (exp_q[t].size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_beat: got tid %0d data %0h, required no beat", t, bus.m_axis_tdata);
        end else begin
          e = exp_q[t].pop_front();
          check("beat", {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tkeep},
                {e.d, e.l, e.u, 1'b1});
        end
        cur_src = bus.m_axis_tlast ? -1 : t;
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  // Frame driver: expected beats are queued when the frame is created.
  task automatic send_frame(input int unsigned s, input int len, input int base,
                            input int gap_at, input int gap_len, input bit rnd_gap);
    logic [1:0] si;
    beat_t b [$];
    int w;
    si = 2'(s);
    for (int i = 0; i < len; i++) begin
      beat_t x;
      x.d = (base >= 0) ? 8'(base + i) : 8'($urandom);
      x.l = (i == len - 1);
      x.u = 1'($urandom);
      b.push_back(x);
      exp_q[si].push_back(x);
    end
    for (int i = 0; i < len; i++) begin
      if (i == gap_at || (rnd_gap && $urandom_range(0, 3) == 0)) begin
        sv[si] = 1'b0;
        repeat ((i == gap_at) ? gap_len : $urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      sd[si] = b[i].d; sl[si] = b[i].l; su[si] = b[i].u; sk[si] = 1'($urandom); sv[si] = 1'b1;
      w = 0;
      do begin @(negedge clk); w++; end while (!bus.s_axis_tready[si] && w < 2000 && !abort);
      if (abort) begin sv[si] = 1'b0; return; end
      if (!bus.s_axis_tready[si]) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout: got no tready on stream %0d, required one within 2000 cycles", s);
        abort = 1'b1; sv[si] = 1'b0; return;
      end
      @(posedge clk); #1;
    end
    sv[si] = 1'b0;
  endtask

  task automatic src_run(input int unsigned s, input int n);
    for (int f = 0; f < n && !abort; f++) begin
      send_frame(s, $urandom_range(1, 5), -1, -1, 0, 1'b1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_log(input int n, input string name);
    int w = 0;
    while (log_q.size() < n && w < 200) begin @(negedge clk); w++; end
    if (log_q.size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got %0d beats, required %0d", name, log_q.size(), n);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < S; i++) exp_q[i].delete();
    log_q.delete();
    cur_src = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < S; i++) begin sv[i] = 1'b0; sd[i] = '0; sl[i] = 1'b0; su[i] = 1'b0; sk[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_mvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("rst_ready",  32'(bus.s_axis_tready), 32'd0);
    check("rst_busy",   32'(status_busy), 32'd0);
    check("rst_grant",  32'(status_grant), 32'd0);
    clear_model();
    rst_n = 1'b1;
    t0 = cyc;
  endtask

  initial begin
    int rc;
    // 1: single 3-beat frame on stream 2, timing from reset release
    do_reset();
    mrdy = 1'b1;
    @(posedge clk); #1;
    fork
      send_frame(2, 3, 'hA1, -1, 0, 1'b0);
      begin
        rc = 0;
        do begin @(negedge clk); rc++; end while (!bus.s_axis_tready[2] && rc < 20);
        check("t1_ready_cycle", 32'(cyc - t0), 32'd2);
      end
    join
    wait_log(3, "t1_beats");
    for (int i = 0; i < 3 && i < log_q.size(); i++) begin
      check("t1_cycle", 32'(log_q[i].c), 32'(3 + i));
      check("t1_tid",   32'(log_q[i].tid), 32'd2);
      check("t1_data",  {log_q[i].d, 23'd0, log_q[i].l}, {8'(8'hA1 + i), 23'd0, 1'(i == 2)});
    end

    // 2: all streams continuously valid with 1-beat frames -> strict rotation, 2 cycles apart
    do_reset();
    mrdy = 1'b1;
    fork
      repeat (2) send_frame(0, 1, -1, -1, 0, 1'b0);
      repeat (2) send_frame(1, 1, -1, -1, 0, 1'b0);
      repeat (2) send_frame(2, 1, -1, -1, 0, 1'b0);
      repeat (2) send_frame(3, 1, -1, -1, 0, 1'b0);
    join
    wait_log(8, "t2_beats");
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("t2_tid", 32'(log_q[i].tid), 32'(i % S));
      if (i > 0) check("t2_spacing", 32'(log_q[i].c - log_q[i-1].c), 32'd2);
    end

    // 3: sink stalls 5 cycles mid-frame on stream 1
    log_q.delete();
    fork
      send_frame(1, 5, 'h10, -1, 0, 1'b0);
      begin
        wait_log(1, "t3_first");
        @(posedge clk); #1; mrdy = 1'b0;
        repeat (5) @(posedge clk);
        #1; mrdy = 1'b1;
      end
    join
    wait_log(5, "t3_beats");
    check("t3_count", 32'(log_q.size()), 32'd5);

    // 4: stream 0 pauses mid-frame; stream 3 must wait for its tlast
    log_q.delete();
    fork
      send_frame(0, 3, 'h40, 1, 4, 1'b0);
      begin
        rc = 0;
        do begin @(negedge clk); rc++; end while (!bus.s_axis_tready[0] && rc < 20);
        @(posedge clk); #1;
        send_frame(3, 2, 'h70, -1, 0, 1'b0);
      end
    join
    wait_log(5, "t4_beats");
    for (int i = 0; i < 5 && i < log_q.size(); i++)
      check("t4_tid", 32'(log_q[i].tid), (i < 3) ? 32'd0 : 32'd3);

    // 5: reset mid-frame, then lowest-index valid stream wins
    log_q.delete();
    fork
      send_frame(1, 6, 'h20, -1, 0, 1'b0);
      begin
        wait_log(2, "t5_first");
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        check("t5_mvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("t5_ready",  32'(bus.s_axis_tready), 32'd0);
        check("t5_busy",   32'(status_busy), 32'd0);
        abort = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;
      end
    join
    clear_model();
    abort = 1'b0;
    fork
      send_frame(3, 2, 'h30, -1, 0, 1'b0);
      send_frame(2, 2, 'h50, -1, 0, 1'b0);
    join
    wait_log(4, "t5_beats");
    if (log_q.size() >= 4) begin
      check("t5_first_tid",  32'(log_q[0].tid), 32'd2);
      check("t5_second_tid", 32'(log_q[2].tid), 32'd3);
    end

    // 6: random valid/ready traffic on all streams
    log_q.delete();
    done = 1'b0;
    fork
      begin
        fork
          src_run(0, 830);
          src_run(1, 830);
          src_run(2, 830);
          src_run(3, 830);
        join
        done = 1'b1;
      end
      while (!done) begin @(posedge clk); #1; mrdy = ($urandom_range(0, 9) < 7); end
    join
    mrdy = 1'b1;
    rc = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && rc < 200) begin
      @(negedge clk); rc++;
    end
    for (int i = 0; i < S; i++) check("t6_drained", 32'(exp_q[i].size()), 32'd0);
    check("t6_frame_closed", 32'(cur_src), 32'hFFFF_FFFF);
    check("t6_beat_volume", 32'(log_q.size() > 8000), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
